// File: rtl/iter_job_dispatcher.sv
// iter_job_dispatcher: queues host jobs, runs them one at a time on a start/done engine
// and holds each result on a valid/ready output. Optional watchdog macro: IRQ_TIMEOUT_EN.
module iter_job_dispatcher #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 4
`ifdef IRQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_data,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy,
  output logic              spurious
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              spurious_q;
  logic              push, pop, fifo_empty, tmo_hit, finish;

  assign in_ready   = count_q < FULL_CNT;
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid && in_ready;
  // The head leaves the FIFO only when its job finishes, so eng_data is stable for the run.
  assign pop        = finish;
  assign eng_data   = mem_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign spurious   = spurious_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!fifo_empty && !out_valid_q) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (finish) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_LAUNCH: eng_start = 1'b1;
      S_WAIT:   finish    = eng_done || tmo_hit;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      spurious_q  <= 1'b0;
    end else begin
      if (finish) begin
        out_valid_q <= 1'b1;
        out_data_q  <= tmo_hit ? '1 : eng_result;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (eng_done && (state_q != S_WAIT)) spurious_q <= 1'b1;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_q;
  logic          out_err_q;

  // A done arriving in the expiry cycle takes priority over the timeout.
  assign tmo_hit = (state_q == S_WAIT) && !eng_done && (tmo_q == TMO_LAST);
  assign out_err = out_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= '0;
      out_err_q <= 1'b0;
    end else begin
      if (state_q == S_LAUNCH)                 tmo_q <= '0;
      else if (state_q == S_WAIT && !eng_done) tmo_q <= tmo_q + 1'b1;
      if (finish) out_err_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_iter_job_dispatcher.sv
// Self-checking bench for iter_job_dispatcher: vector table, directed corner sequences and
// randomized traffic against a queue-based job/result model with a simple engine model.
module tb_iter_job_dispatcher;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          TMO   = 8;

  logic          clk, rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          eng_start;
  logic [DW-1:0] eng_data;
  logic          eng_done;
  logic [DW-1:0] eng_result;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_err, busy, spurious;

  iter_job_dispatcher #(
    .DATA_W(DW),
    .DEPTH(DEPTH)
`ifdef IRQ_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy), .spurious(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Model: accepted-but-unfinished jobs, result register, engine in flight.
  logic [DW-1:0] job_q[$];
  bit            ov, exp_err, inflight, spur_exp, no_resp, spur_req, rand_lat, last_push;
  logic [DW-1:0] exp_data, cur_op, last_out;
  int            start_c, lat_cur, lat_cfg, starts_n, results_n, push_c, cap_c;

  typedef struct {
    logic [DW-1:0] data;
    int            lat;
    logic [DW-1:0] res;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic capture(input logic [DW-1:0] d, input bit e);
    if (job_q.size() != 0) void'(job_q.pop_front());
    ov       = 1'b1;
    exp_data = d;
    exp_err  = e;
    inflight = 1'b0;
    cap_c    = cyc_n;
  endtask

  // Commit this cycle's inputs to the model, pass one clock, check, then drive the engine.
  task automatic cyc();
    bit push_ok;
    push_ok = in_valid && (job_q.size() < DEPTH);
    if (ov && out_ready) begin
      chk("out_data", out_data, exp_data);
      chk("out_err", out_err, exp_err);
      last_out = out_data;
      ov = 1'b0;
      results_n++;
    end
    if (eng_done) begin
      if (inflight && cyc_n > start_c) capture(~cur_op, 1'b0);
      else spur_exp = 1'b1;
    end
`ifdef IRQ_TIMEOUT_EN
    else if (inflight && (cyc_n - start_c == TMO)) capture('1, 1'b1);
`endif
    if (push_ok) begin
      job_q.push_back(in_data);
      push_c = cyc_n;
    end
    last_push = push_ok;

    @(negedge clk);
    cyc_n++;
    chk("in_ready", in_ready, job_q.size() < DEPTH);
    chk("busy", busy, job_q.size() != 0);
    chk("out_valid", out_valid, ov);
    chk("spurious", spurious, spur_exp);
    if (eng_start) begin
      chk("start_overlap", inflight, 0);
      chk("start_with_result_held", ov, 0);
      chk("start_nonempty", job_q.size() != 0, 1);
      cur_op = (job_q.size() != 0) ? job_q[0] : '0;
      chk("start_operand", eng_data, cur_op);
      inflight = 1'b1;
      start_c  = cyc_n;
      lat_cur  = rand_lat ? int'($urandom_range(1, 6)) : lat_cfg;
      starts_n++;
    end else if (inflight) begin
      chk("eng_data_stable", eng_data, cur_op);
    end
    eng_done   = 1'b0;
    eng_result = DW'($urandom);
    if (inflight && !no_resp && (cyc_n - start_c == lat_cur)) begin
      eng_done   = 1'b1;
      eng_result = ~cur_op;
    end
    if (spur_req) begin
      eng_done = 1'b1;
      spur_req = 1'b0;
    end
  endtask

  task automatic push_job(input logic [DW-1:0] d);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      cyc();
      k++;
    end while (!last_push && k < 60);
    chk("push_accept_timeout", last_push, 1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((job_q.size() != 0 || ov || inflight) && k < budget) begin
      cyc();
      k++;
    end
    chk("drain_timeout", (job_q.size() != 0 || ov || inflight), 0);
  endtask

  initial begin
    int s0, r0, k, rel_c, first_cap;
    tbl[0] = '{8'h5A, 5, 8'hA5};
    tbl[1] = '{8'h00, 1, 8'hFF};
    tbl[2] = '{8'hFF, 2, 8'h00};
    tbl[3] = '{8'h3C, 7, 8'hC3};
    tbl[4] = '{8'h81, 3, 8'h7E};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; eng_done = 1'b0; eng_result = '0;
    out_ready = 1'b0; ov = 0; exp_err = 0; inflight = 0; spur_exp = 0; no_resp = 0;
    spur_req = 0; rand_lat = 0; lat_cfg = 3; starts_n = 0; results_n = 0;
    start_c = 0; push_c = 0; cap_c = 0; last_out = '0; exp_data = '0; cur_op = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spurious", spurious, 0);
    rst_n = 1'b1;

    // Single jobs from the vector table
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lat_cfg = tbl[i].lat;
      s0 = starts_n;
      push_job(tbl[i].data);
      in_valid = 1'b0;
      drain(40);
      chk("tbl_start_latency", start_c - push_c, 2);
      chk("tbl_done_to_capture", cap_c - start_c, tbl[i].lat);
      chk("tbl_start_count", starts_n - s0, 1);
      chk("tbl_result", last_out, tbl[i].res);
    end

    // Back-to-back burst fills the FIFO
    lat_cfg = 3; s0 = starts_n; r0 = results_n;
    for (int i = 1; i <= 4; i++) push_job(DW'(i));
    in_valid = 1'b0;
    chk("burst_in_ready_full", in_ready, 0);
    drain(100);
    chk("burst_starts", starts_n - s0, 4);
    chk("burst_results", results_n - r0, 4);
    chk("burst_last", last_out, 8'hFB);

    // Result held: no launches until the consumer takes it
    out_ready = 1'b0; lat_cfg = 2;
    for (int i = 0; i < 4; i++) push_job(DW'(8'h10 + i));
    in_valid = 1'b0;
    k = 0;
    while (!ov && k < 40) begin cyc(); k++; end
    chk("hold_result_seen", out_valid, 1);
    s0 = starts_n;
    repeat (10) cyc();
    chk("hold_no_start", starts_n - s0, 0);
    chk("hold_busy", busy, 1);
    out_ready = 1'b1;
    rel_c = cyc_n;
    k = 0;
    while (starts_n == s0 && k < 10) begin cyc(); k++; end
    chk("hold_release_start", start_c - rel_c, 2);
    drain(100);

    // eng_done while idle
    spur_req = 1'b1;
    cyc(); cyc();
    chk("spurious_set", spurious, 1);
    repeat (5) cyc();
    chk("spurious_sticky", spurious, 1);
    chk("spurious_no_result", out_valid, 0);

    // Host holds a job while the FIFO is full and the head completes
    lat_cfg = 6;
    for (int i = 0; i < 4; i++) push_job(DW'(8'h21 + i));
    push_job(8'h25);
    first_cap = cap_c;
    in_valid = 1'b0;
    chk("full_push_after_pop", push_c - first_cap, 1);
    drain(150);
    chk("full_last_result", last_out, 8'hDA);

`ifdef IRQ_TIMEOUT_EN
    out_ready = 1'b0; no_resp = 1'b1;
    push_job(8'h77);
    in_valid = 1'b0;
    k = 0;
    while (!ov && k < 40) begin cyc(); k++; end
    chk("tmo_latency", cyc_n - start_c, TMO + 1);
    chk("tmo_valid", out_valid, 1);
    chk("tmo_err", out_err, 1);
    chk("tmo_data", out_data, 8'hFF);
    out_ready = 1'b1; no_resp = 1'b0; lat_cfg = 2;
    push_job(8'h66);
    in_valid = 1'b0;
    drain(60);
    chk("tmo_next_result", last_out, 8'h99);
    chk("tmo_next_err", out_err, 0);
`endif

    // Randomized traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(300);
    chk("total_starts_vs_results", starts_n, results_n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
